ibex_register_file_ff_mp: RTL

Flip-flop register file with a configurable number of read and write ports, for dual-issue and decoupled-load Ibex configurations.
- Adds a per-register pending-write scoreboard, optional write-to-read bypass, write-port collision arbitration, and a registered integrity error.
- Sits in the ID stage. It replaces the single-write-port FF register file when NumWritePorts > 1 or when load/store-unit (LSU) writeback is decoupled.

---
 rtl/ibex_rf_pkg.sv | 17 +
 rtl/ibex_register_file_ff_mp_if.sv | 36 +++
 rtl/ibex_rf_scoreboard.sv | 44 ++++
 rtl/ibex_register_file_ff_mp.sv | 132 +++++++++++++
 4 files changed

// File: rtl/ibex_rf_pkg.sv
// Shared definitions for the multi-port flip-flop register file.
// Provides the architectural address width, port-count limits, the
// register address type and a helper returning the register count.
package ibex_rf_pkg;

    localparam int unsigned RfAddrW       = 5;
    localparam int unsigned MaxReadPorts  = 4;
    localparam int unsigned MaxWritePorts = 3;

    typedef logic [RfAddrW-1:0] rf_addr_t;

    // RV32E exposes 16 architectural registers, RV32I exposes 32.
    function automatic int unsigned rf_num_words(input bit rv32e);
        return rv32e ? 32'd16 : 32'd32;
    endfunction

endpackage

// File: rtl/ibex_register_file_ff_mp_if.sv
// Bus interface of the multi-port register file.
// master: the ID stage. It drives the read addresses, the write ports, the
//         pending-write marks and the dummy-instruction flag.
// slave : the register file. It returns read data, read-valid bits, the
//         scoreboard vector and the registered error pulse.
interface ibex_register_file_ff_mp_if
    import ibex_rf_pkg::*;
#(
    parameter int unsigned NumReadPorts  = 2,
    parameter int unsigned NumWritePorts = 2,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned Words         = 32
);
    logic                                      dummy_instr_id_i;
    rf_addr_t [NumReadPorts-1:0]               raddr_i;
    logic     [NumReadPorts-1:0][DataWidth-1:0] rdata_o;
    logic     [NumReadPorts-1:0]               rvalid_o;
    rf_addr_t [NumWritePorts-1:0]              waddr_i;
    logic     [NumWritePorts-1:0][DataWidth-1:0] wdata_i;
    logic     [NumWritePorts-1:0]              we_i;
    logic                                      pend_set_i;
    rf_addr_t                                  pend_addr_i;
    logic     [Words-1:0]                      pend_o;
    logic                                      err_o;

    modport master (
        output dummy_instr_id_i, raddr_i, waddr_i, wdata_i, we_i, pend_set_i, pend_addr_i,
        input  rdata_o, rvalid_o, pend_o, err_o
    );

    modport slave (
        input  dummy_instr_id_i, raddr_i, waddr_i, wdata_i, we_i, pend_set_i, pend_addr_i,
        output rdata_o, rvalid_o, pend_o, err_o
    );

endinterface

// File: rtl/ibex_rf_scoreboard.sv
// Pending-write scoreboard. One flop per register marks an outstanding
// producer, for example a decoupled load.
// Ports: clk_i/rst_ni; pend_set_i/pend_addr_i mark a register;
//        we_dec_i holds the decoded effective writes of every port, and these
//        clear marks; pend_o is the scoreboard state (bit 0 is always 0).
module ibex_rf_scoreboard
    import ibex_rf_pkg::*;
#(
    parameter int unsigned Words         = 32,
    parameter int unsigned NumWritePorts = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  pend_set_i,
    input  rf_addr_t                              pend_addr_i,
    input  logic [NumWritePorts-1:0][Words-1:0]   we_dec_i,
    output logic [Words-1:0]                      pend_o
);

    logic [Words-1:0] pend_q, pend_d, set_vec, clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        // Loop starts at 1: R0 never carries a pending write. The full 5-bit
        // compare also drops out-of-range addresses in RV32E.
        for (int w = 1; w < Words; w++) begin
            set_vec[w] = pend_set_i && (pend_addr_i == rf_addr_t'(w));
        end
        for (int p = 0; p < NumWritePorts; p++) begin
            clr_vec = clr_vec | we_dec_i[p];
        end
        // Set wins over clear: a new producer was issued in the same cycle.
        pend_d = (pend_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pend_q <= '0;
        else         pend_q <= pend_d;
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/ibex_register_file_ff_mp.sv
// Flip-flop register file with multiple read and write ports.
// Port 0 has the highest write priority. The file provides optional
// write-to-read bypass, a pending-write scoreboard and a registered error
// pulse that flags write collisions and out-of-range RV32E writes.
// Ports: clk_i/rst_ni (asynchronous, active-low); rf_if (slave) carries
//        read/write ports, pend marks, pend_o and err_o.
module ibex_register_file_ff_mp
    import ibex_rf_pkg::*;
#(
    parameter bit                    RV32E             = 1'b0,
    parameter int unsigned           DataWidth         = 32,
    parameter int unsigned           NumReadPorts      = 2,
    parameter int unsigned           NumWritePorts     = 2,
    parameter bit                    WriteBypass       = 1'b1,
    parameter bit                    DummyInstructions = 1'b0,
    parameter logic [DataWidth-1:0]  WordZeroVal       = '0
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    ibex_register_file_ff_mp_if.slave rf_if
);

    localparam int unsigned Words = rf_num_words(RV32E);
    localparam int unsigned AddrW = RV32E ? 4 : 5;

    logic [NumWritePorts-1:0][Words-1:0] we_dec;
    logic [NumWritePorts-1:0]            coll, oor;
    logic                                shadow;
    logic                                r0_we;
    logic [Words-1:0][DataWidth-1:0]     rf_q, rf_d;
    logic [Words-1:0]                    pend;
    logic                                err_q;

    // Write arbitration. A port's write is effective only when no
    // higher-priority port targets the same register.
    always_comb begin
        we_dec = '0;
        coll   = '0;
        oor    = '0;
        shadow = 1'b0;
        for (int p = 0; p < NumWritePorts; p++) begin
            shadow = 1'b0;
            for (int q = 0; q < p; q++) begin
                if (rf_if.we_i[q] && (rf_if.waddr_i[q] == rf_if.waddr_i[p])) shadow = 1'b1;
            end
            if (rf_if.we_i[p]) begin
                if (RV32E && rf_if.waddr_i[p][4]) begin
                    oor[p] = 1'b1;
                end else if (rf_if.waddr_i[p] != '0) begin
                    if (shadow) coll[p] = 1'b1;
                    else        we_dec[p][rf_if.waddr_i[p][AddrW-1:0]] = 1'b1;
                end
            end
        end
    end

    // R0 has storage only for dummy instructions. Otherwise it stays at
    // WordZeroVal.
    assign r0_we = DummyInstructions && rf_if.we_i[0] && rf_if.dummy_instr_id_i &&
                   (rf_if.waddr_i[0] == '0);

    always_comb begin
        rf_d = rf_q;
        if (r0_we) rf_d[0] = rf_if.wdata_i[0];
        for (int w = 1; w < Words; w++) begin
            for (int p = 0; p < NumWritePorts; p++) begin
                if (we_dec[p][w]) rf_d[w] = rf_if.wdata_i[p];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_q  <= {Words{WordZeroVal}};
            err_q <= 1'b0;
        end else begin
            rf_q  <= rf_d;
            err_q <= |{coll, oor};
        end
    end

    ibex_rf_scoreboard #(
        .Words         (Words),
        .NumWritePorts (NumWritePorts)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .pend_set_i  (rf_if.pend_set_i),
        .pend_addr_i (rf_if.pend_addr_i),
        .we_dec_i    (we_dec),
        .pend_o      (pend)
    );

    // Read ports. Each port muxes the stored word, applies the R0 and
    // out-of-range rules, and then the optional same-cycle bypass.
    logic [NumReadPorts-1:0][DataWidth-1:0] rdata;
    logic [NumReadPorts-1:0]                rvalid;
    logic [AddrW-1:0]                       ridx;

    always_comb begin
        rdata  = '0;
        rvalid = '1;
        ridx   = '0;
        for (int r = 0; r < NumReadPorts; r++) begin
            rdata[r]  = WordZeroVal;
            rvalid[r] = 1'b1;
            ridx      = rf_if.raddr_i[r][AddrW-1:0];
            if (!(RV32E && rf_if.raddr_i[r][4])) begin
                if (ridx != '0) begin
                    rdata[r]  = rf_q[ridx];
                    rvalid[r] = !pend[ridx];
                    if (WriteBypass) begin
                        for (int p = 0; p < NumWritePorts; p++) begin
                            if (we_dec[p][ridx]) begin
                                rdata[r]  = rf_if.wdata_i[p];
                                rvalid[r] = 1'b1;
                            end
                        end
                    end
                end else if (DummyInstructions && rf_if.dummy_instr_id_i) begin
                    rdata[r] = rf_q[0];
                end
            end
        end
    end

    assign rf_if.rdata_o  = rdata;
    assign rf_if.rvalid_o = rvalid;
    assign rf_if.pend_o   = pend;
    assign rf_if.err_o    = err_q;

endmodule
